// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache
// (16 lines x 32 bytes) with a single-outstanding line refill engine.
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   cpu_req_i/cpu_we_i/cpu_addr_i/cpu_data_i : MEM-stage access
//   cpu_data_o  : load data (combinational on a load hit, else 0)
//   mem_stall_o : freeze the pipeline and PC
//   mem_req_o/mem_we_o/mem_addr_o/mem_data_o : line transfer request
//   mem_data_i/mem_ack_i : refill line and one-cycle completion pulse
module dcache_ctrl (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         mem_stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_ALLOC
  } state_t;

  state_t r_state;

  logic [255:0] r_data [16];
  logic [22:0]  r_tag  [16];
  logic [15:0]  r_valid;
  logic [15:0]  r_dirty;

  logic         r_mem_req;
  logic         r_mem_we;
  logic [31:0]  r_mem_addr;
  logic [255:0] r_mem_data;

  logic [22:0]  w_tag;
  logic [3:0]   w_idx;
  logic [2:0]   w_word;
  logic [7:0]   w_bit;
  logic [255:0] w_line;
  logic         w_idle;
  logic         w_hit;
  logic         w_miss;
  logic         w_st_hit;
  logic         w_ld_hit;
  logic         w_refill;

  assign w_tag    = cpu_addr_i[31:9];
  assign w_idx    = cpu_addr_i[8:5];
  assign w_word   = cpu_addr_i[4:2];
  assign w_bit    = {w_word, 5'b0};
  assign w_line   = r_data[w_idx];
  assign w_idle   = (r_state == S_IDLE);

  assign w_hit    = cpu_req_i & r_valid[w_idx]
                  & (r_tag[w_idx] == w_tag);
  assign w_miss   = w_idle & cpu_req_i & ~w_hit;
  assign w_st_hit = w_idle & w_hit & cpu_we_i;
  assign w_ld_hit = w_idle & w_hit & ~cpu_we_i;
  assign w_refill = (r_state == S_ALLOC) & mem_ack_i;

  assign cpu_data_o  = w_ld_hit ? w_line[w_bit +: 32]
                                : 32'h0;
  assign mem_stall_o = w_idle ? (cpu_req_i & ~w_hit)
                              : 1'b1;

  assign mem_req_o  = r_mem_req;
  assign mem_we_o   = r_mem_we;
  assign mem_addr_o = r_mem_addr;
  assign mem_data_o = r_mem_data;

  // Data and tag storage carry no reset; valid bits gate their use.
  always_ff @(posedge clk_i) begin
    if (w_refill) begin
      r_data[w_idx] <= mem_data_i;
      r_tag[w_idx]  <= w_tag;
    end else if (w_st_hit) begin
      r_data[w_idx][w_bit +: 32] <= cpu_data_i;
    end
  end

  // Transfer outputs are registered and loaded on the transition
  // into each state, so they are valid for the whole state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_dirty    <= '0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_st_hit) begin
            r_dirty[w_idx] <= 1'b1;
          end else if (w_miss) begin
            r_mem_req <= 1'b1;
            if (r_valid[w_idx] & r_dirty[w_idx]) begin
              r_state    <= S_WB;
              r_mem_we   <= 1'b1;
              r_mem_addr <= {r_tag[w_idx], w_idx, 5'b0};
              r_mem_data <= w_line;
            end else begin
              r_state    <= S_ALLOC;
              r_mem_we   <= 1'b0;
              r_mem_addr <= {w_tag, w_idx, 5'b0};
              r_mem_data <= '0;
            end
          end
        end
        S_WB: begin
          if (mem_ack_i) begin
            r_state    <= S_ALLOC;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {w_tag, w_idx, 5'b0};
            r_mem_data <= '0;
          end
        end
        S_ALLOC: begin
          if (mem_ack_i) begin
            r_state        <= S_IDLE;
            r_mem_req      <= 1'b0;
            r_mem_addr     <= '0;
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  // The requester must hold the access steady while stalled.
  a_hold: assert property (
    @(posedge clk_i) disable iff (!rst_i)
    mem_stall_o |=> ($stable(cpu_addr_i)
                 && $stable(cpu_we_i)
                 && $stable(cpu_data_i)));

endmodule
